exc_redirect_ctrl: RTL and testbench
====================================

# exc_redirect_ctrl

Exception and PC-redirect controller for the 5-stage MIPS pipeline. Arbitrates each cycle between sequential fetch, branch/jump redirects from the NPC unit, syscall entry, ERET return and external interrupts. Owns CP0 Status(12), Cause(13) and EPC(14), and drives the PC write enable, PC source select and IF/ID and ID/EX flushes. Sits beside the NPC unit in ID; the PC register and pipeline registers obey its outputs.

## Interface
- EXC_VECTOR, 30'h0000_0C00, word address of the exception handler (byte 0x3000)
- NUM_IRQ, 4, number of level-sensitive interrupt lines (1..8)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real (non-bubble) instruction
- id_pc  in  30  word address of the ID instruction plus 1
- id_syscall  in  1  ID instruction is syscall
- id_eret  in  1  ID instruction is ERET
- br_taken  in  1  NPC unit requests a branch/jump/jr redirect
- br_target  in  30  redirect word address from the NPC unit
- hazard_stall  in  1  load-use stall from the hazard unit
- irq  in  NUM_IRQ  interrupt request lines, active-high
- mtc0_we  in  1  CP0 write strobe
- mtc0_sel  in  5  CP0 write register number
- mtc0_data  in  32  CP0 write data
- mfc0_sel  in  5  CP0 read register number
- mfc0_data  out  32  CP0 read data (combinational)
- pc_we  out  1  PC register load enable
- npc_sel  out  2  00 sequential, 01 branch, 10 exception vector, 11 EPC
- next_pc  out  30  redirect address for sel 01/10/11; 0 for sel 00
- flush_ifid  out  1  squash IF/ID register
- flush_idex  out  1  squash ID/EX register
- exl  out  1  Status.EXL
- epc  out  32  EPC contents (CPR14)

## Operation
- States: IDLE, FLUSH, ENTER.
- Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; all other bits read 0. Cause: bits[6:2] ExcCode (0 = Int, 8 = Sys), bits[8+NUM_IRQ-1:8] IP = live irq. EPC: byte address, bits[1:0] = 0.
- irq_ok = id_valid & IE & ~EXL & |(irq & IM) & ~br_taken.
- IDLE priority, evaluated only when hazard_stall=0:
  - irq_ok: EPC <= {id_pc-1,2'b00}, ExcCode <= 0, EXL <= 1. Go to FLUSH.
  - id_valid & id_syscall & ~EXL: EPC <= {id_pc,2'b00}, ExcCode <= 8, EXL <= 1. Go to FLUSH.
  - id_valid & id_eret: pc_we=1, npc_sel=11, next_pc=EPC[31:2], flush_ifid=1, EXL <= 0.
  - br_taken: pc_we=1, npc_sel=01, next_pc=br_target, flush_ifid=1.
  - Otherwise: pc_we=1, npc_sel=00.
- hazard_stall=1 in IDLE: pc_we=0, no flush, no event accepted, no CP0 hardware update.
- FLUSH (1 cycle): pc_we=0, flush_ifid=1, flush_idex=1. Go to ENTER.
- ENTER (1 cycle): pc_we=1, npc_sel=10, next_pc=EXC_VECTOR, flush_ifid=1. Go to IDLE.
- hazard_stall is ignored in FLUSH and ENTER.
- syscall with EXL=1 is treated as a nop (sequential). The handler is not re-entered.
- mtc0: sel 12 writes IE/IM/EXL; sel 14 writes EPC with [1:0] forced 0; sel 13 and other selects are ignored. A hardware update in the same cycle wins over mtc0, field by field.
- mfc0_data: Status, Cause or EPC for sel 12/13/14; 0 otherwise.

## Timing
- Reset: state IDLE, Status=0, ExcCode=0, EPC=0. During rst=1: pc_we=0, npc_sel=00, next_pc=0, flush_ifid=0, flush_idex=0.
- Branch, ERET and sequential decisions are combinational in the same cycle as the inputs.
- Exception latency: accept cycle (IDLE, pc_we=0, flush_ifid=1, flush_idex=1), then FLUSH, then ENTER. The handler's first instruction is fetched 3 cycles after acceptance.
- CP0 state updates on the clock edge ending the accept cycle; exl is visible from the FLUSH cycle.
- Reset asserted in FLUSH or ENTER aborts the sequence; the next state is IDLE with Status cleared.
- An irq deasserted after acceptance does not cancel entry.

## Configuration
- EXC_CTRL_IRQ_EN defined: interrupt path as above.
- EXC_CTRL_IRQ_EN undefined:
  - irq_ok is constant 0.
  - Cause.IP and Status.IM read 0, and IM writes are ignored.
  - Only syscall and ERET enter or leave the handler.

## Test plan
- Reset, then idle with no events: pc_we=1, npc_sel=00, mfc0 of sel 12/13/14 each return 0.
- br_taken=1, br_target=30'h40: same-cycle pc_we=1, npc_sel=01, next_pc=30'h40, flush_ifid=1. Repeat with hazard_stall=1: pc_we=0, no flush.
- syscall in ID with id_pc=30'h105:
  - Entry: EPC=32'h414, ExcCode=8, EXL=1; FLUSH then ENTER; next_pc=EXC_VECTOR.
  - Then ERET: npc_sel=11, next_pc=30'h105, EXL=0.
- With EXC_CTRL_IRQ_EN, Status=32'h0101, irq=4'b0001, id_pc=30'h200:
  - EPC=32'h7FC, ExcCode=0, entry taken.
  - Same stimulus with br_taken=1: entry deferred; branch taken instead.
- mtc0 sel 14 = 32'h1234 in the same cycle a syscall is accepted: EPC takes the hardware value. rst asserted during FLUSH: state returns to IDLE and ENTER never occurs.

Source files
------------

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl
// Exception and PC-redirect controller for a 5-stage MIPS pipeline.
// Each cycle it chooses between sequential fetch, NPC-unit redirects,
// syscall entry, ERET return and external interrupts. It owns CP0 Status(12),
// Cause(13) and EPC(14), and drives the PC load enable, PC source select and
// the IF/ID and ID/EX flushes.
//
// Optional feature macro: EXC_CTRL_IRQ_EN enables the interrupt path.
// When it is undefined, irq_i is ignored and Status.IM / Cause.IP read 0.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   id_valid_i, id_pc_i  ID holds a real instruction; its word address + 1
//   id_syscall_i         ID instruction is syscall
//   id_eret_i            ID instruction is ERET
//   br_taken_i           NPC unit redirect request
//   br_target_i          NPC unit redirect word address
//   hazard_stall_i       load-use stall
//   irq_i                level-sensitive interrupt lines
//   mtc0_we_i/sel_i/data_i  CP0 write port
//   mfc0_sel_i, mfc0_data_o CP0 combinational read port
//   pc_we_o, npc_sel_o, next_pc_o  PC control (00 seq, 01 br, 10 vector, 11 EPC)
//   flush_ifid_o, flush_idex_o     pipeline squashes
//   exl_o, epc_o         Status.EXL and EPC contents
module exc_redirect_ctrl #(
  parameter logic [29:0] EXC_VECTOR = 30'h0000_0C00,
  parameter int unsigned NUM_IRQ    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [29:0]        id_pc_i,
  input  logic               id_syscall_i,
  input  logic               id_eret_i,
  input  logic               br_taken_i,
  input  logic [29:0]        br_target_i,
  input  logic               hazard_stall_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mtc0_we_i,
  input  logic [4:0]         mtc0_sel_i,
  input  logic [31:0]        mtc0_data_i,
  input  logic [4:0]         mfc0_sel_i,
  output logic [31:0]        mfc0_data_o,
  output logic               pc_we_o,
  output logic [1:0]         npc_sel_o,
  output logic [29:0]        next_pc_o,
  output logic               flush_ifid_o,
  output logic               flush_idex_o,
  output logic               exl_o,
  output logic [31:0]        epc_o
);

  typedef enum logic [1:0] {StIdle, StFlush, StEnter} state_e;

  state_e             state_q, state_d;
  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic [NUM_IRQ-1:0] im_q, im_d;
  logic [4:0]         exccode_q, exccode_d;
  logic [29:0]        epc_q, epc_d;

  logic               irq_ok;
  logic [NUM_IRQ-1:0] ip_w;
  logic [NUM_IRQ-1:0] im_wr_w;
  logic [31:0]        status_w;
  logic [31:0]        cause_w;
  logic               unused_bits;

`ifdef EXC_CTRL_IRQ_EN
  assign irq_ok  = id_valid_i & ie_q & ~exl_q & (|(irq_i & im_q)) & ~br_taken_i;
  assign ip_w    = irq_i;
  assign im_wr_w = mtc0_data_i[8 +: NUM_IRQ];
`else
  assign irq_ok  = 1'b0;
  assign ip_w    = '0;
  assign im_wr_w = '0;
`endif

  // Not every write-data bit lands in a CP0 field.
  assign unused_bits = ^{mtc0_data_i, irq_i};

  always_comb begin
    status_w               = '0;
    status_w[0]            = ie_q;
    status_w[1]            = exl_q;
    status_w[8 +: NUM_IRQ] = im_q;
    cause_w                = '0;
    cause_w[6:2]           = exccode_q;
    cause_w[8 +: NUM_IRQ]  = ip_w;
  end

  always_comb begin
    case (mfc0_sel_i)
      5'd12:   mfc0_data_o = status_w;
      5'd13:   mfc0_data_o = cause_w;
      5'd14:   mfc0_data_o = {epc_q, 2'b00};
      default: mfc0_data_o = '0;
    endcase
  end

  assign exl_o = exl_q;
  assign epc_o = {epc_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    ie_d         = ie_q;
    exl_d        = exl_q;
    im_d         = im_q;
    exccode_d    = exccode_q;
    epc_d        = epc_q;
    pc_we_o      = 1'b0;
    npc_sel_o    = 2'b00;
    next_pc_o    = '0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;

    // Software writes first; hardware updates below override field by field.
    if (mtc0_we_i) begin
      case (mtc0_sel_i)
        5'd12: begin
          ie_d  = mtc0_data_i[0];
          exl_d = mtc0_data_i[1];
          im_d  = im_wr_w;
        end
        5'd14:   epc_d = mtc0_data_i[31:2];
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (!hazard_stall_i) begin
          if (irq_ok) begin
            // Interrupted instruction has not executed: resume at it.
            epc_d        = id_pc_i - 30'd1;
            exccode_d    = 5'd0;
            exl_d        = 1'b1;
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
            state_d      = StFlush;
          end else if (id_valid_i && id_syscall_i && !exl_q) begin
            epc_d        = id_pc_i;
            exccode_d    = 5'd8;
            exl_d        = 1'b1;
            flush_ifid_o = 1'b1;
            flush_idex_o = 1'b1;
            state_d      = StFlush;
          end else if (id_valid_i && id_eret_i) begin
            pc_we_o      = 1'b1;
            npc_sel_o    = 2'b11;
            next_pc_o    = epc_q;
            flush_ifid_o = 1'b1;
            exl_d        = 1'b0;
          end else if (br_taken_i) begin
            pc_we_o      = 1'b1;
            npc_sel_o    = 2'b01;
            next_pc_o    = br_target_i;
            flush_ifid_o = 1'b1;
          end else begin
            pc_we_o = 1'b1;
          end
        end
      end
      StFlush: begin
        flush_ifid_o = 1'b1;
        flush_idex_o = 1'b1;
        state_d      = StEnter;
      end
      StEnter: begin
        pc_we_o      = 1'b1;
        npc_sel_o    = 2'b10;
        next_pc_o    = EXC_VECTOR;
        flush_ifid_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rst_i) begin
      pc_we_o      = 1'b0;
      npc_sel_o    = 2'b00;
      next_pc_o    = '0;
      flush_ifid_o = 1'b0;
      flush_idex_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Self-checking bench for exc_redirect_ctrl: a cycle-level model of the
// controller's observable behaviour is compared every negedge, and directed
// literal checks pin the model.
module tb_exc_redirect_ctrl;

`ifdef EXC_CTRL_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif
  localparam logic [29:0] Vec = 30'h0000_0C00;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [29:0] id_pc;
  logic        id_syscall, id_eret, br_taken;
  logic [29:0] br_target;
  logic        hazard_stall;
  logic [3:0]  irq;
  logic        mtc0_we;
  logic [4:0]  mtc0_sel, mfc0_sel;
  logic [31:0] mtc0_data, mfc0_data;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic [29:0] next_pc;
  logic        flush_ifid, flush_idex, exl;
  logic [31:0] epc;

  int tests = 0;
  int fails = 0;
  bit running = 1'b0;

  exc_redirect_ctrl #(.EXC_VECTOR(Vec), .NUM_IRQ(4)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_syscall_i(id_syscall), .id_eret_i(id_eret), .br_taken_i(br_taken),
    .br_target_i(br_target), .hazard_stall_i(hazard_stall), .irq_i(irq),
    .mtc0_we_i(mtc0_we), .mtc0_sel_i(mtc0_sel), .mtc0_data_i(mtc0_data),
    .mfc0_sel_i(mfc0_sel), .mfc0_data_o(mfc0_data), .pc_we_o(pc_we),
    .npc_sel_o(npc_sel), .next_pc_o(next_pc), .flush_ifid_o(flush_ifid),
    .flush_idex_o(flush_idex), .exl_o(exl), .epc_o(epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model state: architectural CP0 fields plus how many cycles into an entry.
  logic        m_ie = 0, m_exl = 0;
  logic [3:0]  m_im = 0;
  logic [4:0]  m_exc = 0;
  logic [31:0] m_epc = 0;
  int          m_phase = 0;   // 0 idle, 1 flush cycle, 2 vector-fetch cycle

  always @(negedge clk) begin
    logic        e_we, e_fi, e_fe;
    logic [1:0]  e_sel;
    logic [29:0] e_npc, pcm1;
    logic [31:0] e_rd;
    logic        take_irq, take_sys, do_eret;
    if (running) begin
      e_we = 0; e_sel = 0; e_npc = 0; e_fi = 0; e_fe = 0;
      take_irq = 0; take_sys = 0; do_eret = 0;
      if (!rst) begin
        if (m_phase == 1) begin
          e_fi = 1; e_fe = 1;
        end else if (m_phase == 2) begin
          e_we = 1; e_sel = 2; e_npc = Vec; e_fi = 1;
        end else if (!hazard_stall) begin
          take_irq = IrqEn && id_valid && m_ie && !m_exl && ((irq & m_im) != 0) && !br_taken;
          take_sys = !take_irq && id_valid && id_syscall && !m_exl;
          do_eret  = !take_irq && !take_sys && id_valid && id_eret;
          if (take_irq || take_sys) begin
            e_fi = 1; e_fe = 1;
          end else if (do_eret) begin
            e_we = 1; e_sel = 3; e_npc = m_epc[31:2]; e_fi = 1;
          end else if (br_taken) begin
            e_we = 1; e_sel = 1; e_npc = br_target; e_fi = 1;
          end else begin
            e_we = 1;
          end
        end
      end
      case (mfc0_sel)
        5'd12:   e_rd = {20'd0, (IrqEn ? m_im : 4'd0), 6'd0, m_exl, m_ie};
        5'd13:   e_rd = {20'd0, (IrqEn ? irq : 4'd0), 1'b0, m_exc, 2'b00};
        5'd14:   e_rd = m_epc;
        default: e_rd = 0;
      endcase
      chk("m_pc_we", {31'd0, pc_we}, {31'd0, e_we});
      chk("m_npc_sel", {30'd0, npc_sel}, {30'd0, e_sel});
      chk("m_next_pc", {2'd0, next_pc}, {2'd0, e_npc});
      chk("m_flush_ifid", {31'd0, flush_ifid}, {31'd0, e_fi});
      chk("m_flush_idex", {31'd0, flush_idex}, {31'd0, e_fe});
      chk("m_exl", {31'd0, exl}, {31'd0, m_exl});
      chk("m_epc", epc, m_epc);
      chk("m_mfc0", mfc0_data, e_rd);
      // Advance the model to the state after the coming clock edge.
      if (rst) begin
        m_ie = 0; m_exl = 0; m_im = 0; m_exc = 0; m_epc = 0; m_phase = 0;
      end else begin
        if (mtc0_we && mtc0_sel == 5'd12) begin
          m_ie = mtc0_data[0]; m_exl = mtc0_data[1];
          m_im = IrqEn ? mtc0_data[11:8] : 4'd0;
        end
        if (mtc0_we && mtc0_sel == 5'd14) m_epc = {mtc0_data[31:2], 2'b00};
        if (take_irq) begin
          pcm1 = id_pc - 30'd1;
          m_epc = {pcm1, 2'b00}; m_exc = 0; m_exl = 1;
        end
        if (take_sys) begin
          m_epc = {id_pc, 2'b00}; m_exc = 8; m_exl = 1;
        end
        if (do_eret) m_exl = 0;
        if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) m_phase = 0;
        else if (take_irq || take_sys) m_phase = 1;
      end
    end
  end

  task automatic clear();
    id_valid = 0; id_pc = 30'h1; id_syscall = 0; id_eret = 0; br_taken = 0;
    br_target = 0; hazard_stall = 0; irq = 0; mtc0_we = 0; mtc0_sel = 0;
    mtc0_data = 0; mfc0_sel = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear();
    rst = 1;
    @(posedge clk); #1;
    running = 1;
    tick();
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    rst = 0; #1;
    chk("idle_pc_we", {31'd0, pc_we}, 32'd1);
    chk("idle_sel", {30'd0, npc_sel}, 32'd0);
    mfc0_sel = 12; #1 chk("rd_status0", mfc0_data, 32'd0);
    mfc0_sel = 13; #1 chk("rd_cause0", mfc0_data, 32'd0);
    tick();
    mfc0_sel = 14; #1 chk("rd_epc0", mfc0_data, 32'd0);
    tick(); clear();

    // Branch redirect, then the same request under a stall.
    br_taken = 1; br_target = 30'h40; #1;
    chk("br_pc_we", {31'd0, pc_we}, 32'd1);
    chk("br_sel", {30'd0, npc_sel}, 32'd1);
    chk("br_next", {2'd0, next_pc}, 32'h40);
    chk("br_flush", {31'd0, flush_ifid}, 32'd1);
    hazard_stall = 1; #1;
    chk("br_stall_we", {31'd0, pc_we}, 32'd0);
    chk("br_stall_flush", {30'd0, flush_ifid, flush_idex}, 32'd0);
    tick(); clear();

    // Syscall accepted with a colliding mtc0 EPC write.
    id_valid = 1; id_pc = 30'h105; id_syscall = 1;
    mtc0_we = 1; mtc0_sel = 14; mtc0_data = 32'h1234; #1;
    chk("sys_acc_we", {31'd0, pc_we}, 32'd0);
    chk("sys_acc_flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
    tick(); clear(); #1;
    chk("sys_fl_flush", {30'd0, flush_ifid, flush_idex}, 32'd3);
    chk("sys_fl_exl", {31'd0, exl}, 32'd1);
    chk("sys_epc", epc, 32'h414);
    mfc0_sel = 13; #1 chk("sys_cause", mfc0_data, 32'h20);
    tick(); clear(); #1;
    chk("sys_ent_sel", {30'd0, npc_sel}, 32'd2);
    chk("sys_ent_next", {2'd0, next_pc}, {2'd0, Vec});
    tick(); #1;
    chk("sys_back_idle", {30'd0, npc_sel}, 32'd0);

    // Syscall inside the handler is a nop.
    id_valid = 1; id_syscall = 1; id_pc = 30'h300; #1;
    chk("sys_exl_nop", {29'd0, pc_we, npc_sel}, 32'h4);
    tick(); clear();

    // ERET returns to EPC and clears EXL.
    id_valid = 1; id_eret = 1; #1;
    chk("eret_sel", {30'd0, npc_sel}, 32'd3);
    chk("eret_next", {2'd0, next_pc}, 32'h105);
    tick(); clear(); #1;
    chk("eret_exl", {31'd0, exl}, 32'd0);

    // Enable IE and IM[0].
    mtc0_we = 1; mtc0_sel = 12; mtc0_data = 32'h0101;
    tick(); clear();
    mfc0_sel = 12; #1;
    chk("status_wr", mfc0_data, IrqEn ? 32'h101 : 32'h1);
    tick(); clear();

    // Interrupt with a branch in ID: branch wins, entry deferred.
    id_valid = 1; id_pc = 30'h200; irq = 4'b0001; br_taken = 1; br_target = 30'h77; #1;
    chk("irq_br_sel", {30'd0, npc_sel}, 32'd1);
    chk("irq_br_next", {2'd0, next_pc}, 32'h77);
    tick();
    br_taken = 0; #1;
    if (IrqEn) begin
      chk("irq_acc", {29'd0, pc_we, flush_ifid, flush_idex}, 32'h3);
      tick(); clear(); #1;
      chk("irq_epc", epc, 32'h7FC);
      mfc0_sel = 13; #1 chk("irq_cause", mfc0_data, 32'd0);
      tick(); clear(); #1;
      chk("irq_ent_sel", {30'd0, npc_sel}, 32'd2);
      tick();
      id_valid = 1; id_eret = 1;
      tick(); clear();
    end else begin
      chk("irq_ignored", {29'd0, pc_we, npc_sel}, 32'h4);
      tick(); clear();
    end

    // Reset during FLUSH aborts the entry.
    id_valid = 1; id_syscall = 1; id_pc = 30'h50;
    tick(); clear();
    rst = 1; #1;
    chk("rstfl_out", {28'd0, pc_we, npc_sel, flush_ifid}, 32'd0);
    tick();
    rst = 0; #1;
    chk("rstfl_idle", {29'd0, pc_we, npc_sel}, 32'h4);
    chk("rstfl_exl", {31'd0, exl}, 32'd0);
    tick(); #1;
    chk("rstfl_no_enter", {29'd0, pc_we, npc_sel}, 32'h4);

    // Cause is read-only; unknown selects read 0.
    mtc0_we = 1; mtc0_sel = 13; mtc0_data = 32'hFFFF_FFFF;
    tick(); clear();
    mfc0_sel = 13; #1 chk("cause_ro", mfc0_data, 32'd0);
    mfc0_sel = 5;  #1 chk("rd_other", mfc0_data, 32'd0);
    tick(); tick();

    running = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
